// File: rtl/div_f_pkg.sv
// Shared constants and elaboration-time helpers for the cascaded frequency divider.
package div_f_pkg;

    localparam int unsigned DEF_CLK_HZ  = 32'd50_000_000;
    localparam int unsigned DEF_BASE_HZ = 32'd100;
    localparam int unsigned DEF_RATIO   = 32'd10;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 32'd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    // True when the divider can be built exactly: even integer prescale, even stage ratio.
    function automatic bit params_ok(input int unsigned clk_hz,
                                     input int unsigned base_hz,
                                     input int unsigned ratio,
                                     input int unsigned stages);
        bit ok;
        ok = 1'b1;
        if (base_hz == 32'd0) begin
            ok = 1'b0;
        end else if ((clk_hz % base_hz) != 32'd0) begin
            ok = 1'b0;
        end else if ((clk_hz / base_hz) < 32'd2 || ((clk_hz / base_hz) % 32'd2) != 32'd0) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        if (ratio < 32'd2 || (ratio % 32'd2) != 32'd0 || stages < 32'd1) begin
            ok = 1'b0;
        end else begin
            ok = ok;
        end
        return ok;
    endfunction

endpackage

// File: rtl/div_f_stage.sv
// One divide-by-RATIO stage of the cascade: counts upstream wraps and produces
// its own tick strobe, square wave and wrap for the next stage.
module div_f_stage
    import div_f_pkg::*;
#(
    parameter int unsigned RATIO = DEF_RATIO
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic CLEAR,
    input  logic wrap_in,
    output logic wrap_out,
    output logic tick,
    output logic sqw
);

    localparam int unsigned CW = (clog2(RATIO) < 32'd1) ? 32'd1 : clog2(RATIO);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 32'd1);
    localparam logic [CW-1:0] CNT_MID  = CW'((RATIO / 32'd2) - 32'd1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;
    logic          sqw_q;
    logic          sqw_d;

    assign wrap_out = wrap_in && (cnt_q == CNT_LAST);
    assign tick     = tick_q;
    assign sqw      = sqw_q;

    // Next-state: advance only when the upstream tap wraps; toggle SQW at mid and terminal count.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sqw_d  = sqw_q;
        if (CLEAR) begin
            cnt_d = '0;
            sqw_d = 1'b0;
        end else if (wrap_in) begin
            cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(32'd1);
            tick_d = wrap_out;
            if (cnt_q == CNT_MID || cnt_q == CNT_LAST) begin
                sqw_d = ~sqw_q;
            end else begin
                sqw_d = sqw_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers, updated on the falling edge like the rest of the divider.
    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            sqw_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            sqw_q  <= sqw_d;
        end
    end

endmodule

// File: rtl/div_f_cascade.sv
// Cascaded frequency divider: a prescaler from CLK_HZ to BASE_HZ followed by
// NUM_STAGES-1 divide-by-STAGE_RATIO stages, each tap giving a tick strobe and square wave.
module div_f_cascade
    import div_f_pkg::*;
#(
    parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
    parameter int unsigned BASE_HZ     = DEF_BASE_HZ,
    parameter int unsigned NUM_STAGES  = 32'd3,
    parameter int unsigned STAGE_RATIO = DEF_RATIO
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  RUN,
    input  logic                  CLEAR,
    output logic [NUM_STAGES-1:0] TICK,
    output logic [NUM_STAGES-1:0] SQW
);

    localparam int unsigned N     = (BASE_HZ == 32'd0) ? 32'd0 : (CLK_HZ / BASE_HZ);
    localparam int unsigned PRE_W = (clog2(N) < 32'd1) ? 32'd1 : clog2(N);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(N - 32'd1);
    localparam logic [PRE_W-1:0] PRE_MID  = PRE_W'((N / 32'd2) - 32'd1);

    if (!params_ok(CLK_HZ, BASE_HZ, STAGE_RATIO, NUM_STAGES)) begin : g_bad_params
        $error("div_f_cascade: CLK_HZ/BASE_HZ and STAGE_RATIO must be even integers >= 2");
    end

    logic [PRE_W-1:0]      pre_q;
    logic [PRE_W-1:0]      pre_d;
    logic                  tick0_q;
    logic                  tick0_d;
    logic                  sqw0_q;
    logic                  sqw0_d;
    logic [NUM_STAGES-1:0] wrap_s;
    logic                  unused_last_wrap_s;

    assign wrap_s[0] = RUN && (pre_q == PRE_LAST);
    assign TICK[0]   = tick0_q;
    assign SQW[0]    = sqw0_q;

    // The final stage's wrap has no downstream consumer.
    assign unused_last_wrap_s = wrap_s[NUM_STAGES-1];

    // Prescaler next-state: count while RUN, hold otherwise; SQW toggles at mid and terminal count.
    always_comb begin
        pre_d   = pre_q;
        tick0_d = 1'b0;
        sqw0_d  = sqw0_q;
        if (CLEAR) begin
            pre_d  = '0;
            sqw0_d = 1'b0;
        end else if (RUN) begin
            pre_d   = wrap_s[0] ? '0 : pre_q + PRE_W'(32'd1);
            tick0_d = wrap_s[0];
            if (pre_q == PRE_MID || pre_q == PRE_LAST) begin
                sqw0_d = ~sqw0_q;
            end else begin
                sqw0_d = sqw0_q;
            end
        end else begin
            pre_d = pre_q;
        end
    end

    // Prescaler registers.
    always_ff @(negedge CLOCK) begin
        if (RESET) begin
            pre_q   <= '0;
            tick0_q <= 1'b0;
            sqw0_q  <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            tick0_q <= tick0_d;
            sqw0_q  <= sqw0_d;
        end
    end

    // Each stage sees the previous tap's wrap, so coincident terminal counts tick together.
    for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
        div_f_stage #(
            .RATIO (STAGE_RATIO)
        ) u_stage (
            .CLOCK    (CLOCK),
            .RESET    (RESET),
            .CLEAR    (CLEAR),
            .wrap_in  (wrap_s[k-1]),
            .wrap_out (wrap_s[k]),
            .tick     (TICK[k]),
            .sqw      (SQW[k])
        );
    end

endmodule

// File: tb/tb_div_f_cascade.sv
// Scoreboard bench for div_f_cascade in a small configuration (N=4, ratio 4, 3 taps).
module tb_div_f_cascade;

    localparam int N = 4;
    localparam int R = 4;
    localparam int S = 3;

    typedef struct {
        int           cyc;
        logic [S-1:0] tick;
        logic [S-1:0] sqw;
    } ev_t;

    logic         CLOCK = 1'b0;
    logic         RESET = 1'b0;
    logic         RUN   = 1'b0;
    logic         CLEAR = 1'b0;
    logic [S-1:0] TICK;
    logic [S-1:0] SQW;

    int           ecount = 0;
    int           total  = 0;
    int           bad    = 0;
    int           m_c    = 0;
    logic [S-1:0] es_prev = '0;
    logic [S-1:0] sqw_prev;
    bit           mon_en = 1'b0;
    ev_t          q[$];

    div_f_cascade #(
        .CLK_HZ      (40),
        .BASE_HZ     (10),
        .NUM_STAGES  (S),
        .STAGE_RATIO (R)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .RUN   (RUN),
        .CLEAR (CLEAR),
        .TICK  (TICK),
        .SQW   (SQW)
    );

    always #5 CLOCK = ~CLOCK;

    always @(negedge CLOCK) ecount <= ecount + 1;

    // Tap k has period N*R^k counting cycles; ticks at each multiple, SQW high in the second half.
    function automatic logic [S-1:0] exp_tick(input int c);
        logic [S-1:0] r;
        int p;
        p = N;
        for (int k = 0; k < S; k++) begin
            r[k] = (c > 0) && ((c % p) == 0);
            p = p * R;
        end
        return r;
    endfunction

    function automatic logic [S-1:0] exp_sqw(input int c);
        logic [S-1:0] r;
        int p;
        p = N;
        for (int k = 0; k < S; k++) begin
            r[k] = (c % p) >= (p / 2);
            p = p * R;
        end
        return r;
    endfunction

    // Drive one edge's inputs and push the expected visible outputs after that edge.
    task automatic step(input logic r, input logic c, input logic run);
        logic [S-1:0] et;
        logic [S-1:0] es;
        @(posedge CLOCK);
        RESET = r;
        CLEAR = c;
        RUN   = run;
        if (r || c) begin
            m_c = 0;
            et  = '0;
            es  = '0;
        end else if (run) begin
            m_c = m_c + 1;
            et  = exp_tick(m_c);
            es  = exp_sqw(m_c);
        end else begin
            et = '0;
            es = exp_sqw(m_c);
        end
        if (et != '0 || es != es_prev) begin
            q.push_back('{cyc: ecount + 1, tick: et, sqw: es});
        end
        es_prev = es;
    endtask

    task automatic run_n(input int n, input logic run);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, run);
        end
    endtask

    task automatic check_zero(input string name);
        @(negedge CLOCK);
        #1;
        total++;
        if (TICK !== '0 || SQW !== '0) begin
            bad++;
            $display("FAIL %s: tick=%b sqw=%b, need tick=000 sqw=000", name, TICK, SQW);
        end
    endtask

    // Monitor: an output event is any tick or any change of SQW; each must match the queue head.
    always @(posedge CLOCK) begin
        ev_t e;
        #1;
        if (mon_en) begin
            if (TICK != '0 || SQW != sqw_prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: cyc=%0d tick=%b sqw=%b, need no event",
                             ecount, TICK, SQW);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != ecount || e.tick !== TICK || e.sqw !== SQW) begin
                        bad++;
                        $display("FAIL event: cyc=%0d tick=%b sqw=%b, need cyc=%0d tick=%b sqw=%b",
                                 ecount, TICK, SQW, e.cyc, e.tick, e.sqw);
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= ecount) begin
                total++;
                bad++;
                e = q.pop_front();
                $display("FAIL missing_event: cyc=%0d tick=%b sqw=%b, need cyc=%0d tick=%b sqw=%b",
                         ecount, TICK, SQW, e.cyc, e.tick, e.sqw);
            end
        end
        sqw_prev = SQW;
    end

    initial begin
        // Reset, then free-run through the 64-cycle coincidence and beyond.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_zero("reset_state");
        mon_en = 1'b1;
        run_n(200, 1'b1);

        // Pause at pre=2, cnt[1]=3 (count 206), then resume.
        run_n(6, 1'b1);
        run_n(37, 1'b0);
        run_n(20, 1'b1);

        // CLEAR mid-period at cycle 30.
        step(1'b1, 1'b0, 1'b1);
        check_zero("reset_before_clear");
        run_n(29, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check_zero("clear_state");
        run_n(40, 1'b1);

        // CLEAR while paused, then RESET with RUN=0, then RESET and CLEAR together.
        run_n(3, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_zero("clear_paused");
        run_n(10, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check_zero("reset_paused");
        run_n(21, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_zero("reset_and_clear");
        run_n(70, 1'b1);

        run_n(3, 1'b0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: pending=%0d, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_f_cascade.md
Name: div_f_cascade

Overview:
Parametrised successor to the single-rate 100 Hz divider. A base prescaler derives BASE_HZ from CLOCK, and NUM_STAGES-1 cascaded divide-by-STAGE_RATIO stages follow it. With defaults this gives 100 Hz, 10 Hz and 1 Hz taps for the watch and stopwatch logic.
- Each tap provides a one-cycle TICK strobe for use as a clock enable, plus a 50% duty SQW output.
- RUN pauses the chain for stopwatch hold; CLEAR restarts phase.

Parameters:
CLK_HZ, 50_000_000, input clock frequency in Hz.
BASE_HZ, 100, tap-0 rate. N = CLK_HZ/BASE_HZ must be an even integer >= 2; elaboration error otherwise.
NUM_STAGES, 3, number of taps (>= 1).
STAGE_RATIO, 10, divide ratio between adjacent taps; must be even and >= 2; elaboration error otherwise.

Ports:
CLOCK  input  1  system clock; all registers update on the falling edge.
RESET  input  1  synchronous, active-high reset.
RUN    input  1  1 = count, 0 = hold all counters and SQW.
CLEAR  input  1  synchronous phase restart; RESET has priority.
TICK   output NUM_STAGES  TICK[k] is a one-CLOCK-cycle strobe at rate BASE_HZ/STAGE_RATIO^k.
SQW    output NUM_STAGES  SQW[k] is a 50% duty square wave at the same rate as TICK[k].

Behaviour:
- Reset (RESET=1 at an edge):
  - prescale counter pre=0 and all stage counters cnt[k]=0.
  - TICK=0 and SQW=0.
- CLEAR=1 (RESET=0): identical effect to reset, regardless of RUN.
- Prescaler: pre counts 0..N-1 while RUN=1 and wraps to 0. Width is clog2(N).
- Wrap conditions (combinational):
  - wrap[0] = RUN & (pre==N-1).
  - wrap[k] = wrap[k-1] & (cnt[k]==STAGE_RATIO-1), for k >= 1.
- Stage k >= 1: cnt[k] advances only on an edge where wrap[k-1]=1, and wraps from STAGE_RATIO-1 to 0.
- TICK[k] is a register loaded with wrap[k] each edge.
  - Latency: one cycle after the terminal count.
  - Coincident wraps assert the corresponding TICK bits in the same cycle, so taps stay phase-aligned.
  - TICK[k] is never high for 2 consecutive cycles (N >= 2).
- SQW[0] toggles on an edge where RUN=1 and pre is N/2-1 or N-1.
- SQW[k], k >= 1, toggles on an edge where wrap[k-1]=1 and cnt[k] is STAGE_RATIO/2-1 or STAGE_RATIO-1.
- Resulting SQW phase: low for the first half-period after reset/CLEAR, rising edge aligned with the mid-count.
- RUN=0:
  - pre, cnt and SQW hold their values.
  - TICK drives 0 from the next edge.
  - Resuming RUN continues from the held phase; no tick is lost or duplicated.
- RESET or CLEAR mid-period: the partial period is discarded; the first TICK[0] follows N counting cycles later.
- Cycle counts from reset release with RUN=1 held:
  - First TICK[0] is high in cycle N (cycle 0 = first edge after release).
  - First TICK[k] is high in cycle N*STAGE_RATIO^k.

Decomposition:
- Package div_f_pkg holds:
  - clog2 function;
  - default constants DEF_CLK_HZ=50_000_000, DEF_BASE_HZ=100, DEF_RATIO=10;
  - a parameter-legality check function.
- Sub-module div_f_stage is one divide-by-STAGE_RATIO stage.
  - Inputs: CLOCK, RESET, CLEAR, wrap_in.
  - Outputs: wrap_out, tick, sqw.
  - Instantiated NUM_STAGES-1 times via generate.
- The prescaler lives in the top level.

Test Plan:
1. Small config, CLK_HZ=40, BASE_HZ=10 (N=4), STAGE_RATIO=4, NUM_STAGES=3; RESET pulse then RUN=1 for 200 cycles.
   - TICK[0] in cycles 4, 8, 12, …; TICK[1] every 16 cycles; TICK[2] every 64 cycles; all one cycle wide.
   - At cycle 64, TICK[0], TICK[1] and TICK[2] are high together.
2. Same config, check SQW:
   - SQW[0] period 4 cycles (2 high / 2 low).
   - SQW[1] period 16 (8/8).
   - SQW[2] period 64 (32/32).
   - All start low after reset.
3. RUN=0 for 37 cycles starting at pre=2, cnt[1]=3.
   - No TICK during the pause; SQW frozen.
   - After RUN=1, the next TICK[0] arrives after exactly 2 more counting cycles (pre 2→3, then wrap).
   - TICK[1] coincides with that TICK[0].
4. CLEAR pulse at cycle 30, with RUN=1.
   - TICK and SQW are 0 the next cycle.
   - Next TICK[0] four cycles after CLEAR is released; TICK[1] sixteen cycles after.
5. RESET and CLEAR asserted together, and RESET asserted while RUN=0.
   - All outputs 0; counters 0; RESET wins.
6. Default parameters (N=500_000).
   - TICK[0] spacing 500_000 cycles; TICK[2] spacing 50_000_000 cycles (1 Hz).
   - SQW[0] high for exactly 250_000 cycles.
